// File: rtl/seg7_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl_pkg
//   Shared definitions for the multiplexed 7-segment scan controller:
//   active-low segment patterns for hex digits 0-F, the all-off pattern,
//   the per-cycle display mode enum and the slot-length calculation.
//   Segment bit order everywhere is {CG,CF,CE,CD,CC,CB,CA}; 0 = segment lit.
// ---------------------------------------------------------------------------
package seg7_scan_ctrl_pkg;

   localparam logic [6:0] SEG_0   = 7'b100_0000;
   localparam logic [6:0] SEG_1   = 7'b111_1001;
   localparam logic [6:0] SEG_2   = 7'b010_0100;
   localparam logic [6:0] SEG_3   = 7'b011_0000;
   localparam logic [6:0] SEG_4   = 7'b001_1001;
   localparam logic [6:0] SEG_5   = 7'b001_0010;
   localparam logic [6:0] SEG_6   = 7'b000_0010;
   localparam logic [6:0] SEG_7   = 7'b111_1000;
   localparam logic [6:0] SEG_8   = 7'b000_0000;
   localparam logic [6:0] SEG_9   = 7'b001_0000;
   localparam logic [6:0] SEG_A   = 7'b000_1000;
   localparam logic [6:0] SEG_B   = 7'b000_0011;
   localparam logic [6:0] SEG_C   = 7'b100_0110;
   localparam logic [6:0] SEG_D   = 7'b010_0001;
   localparam logic [6:0] SEG_E   = 7'b000_0110;
   localparam logic [6:0] SEG_F   = 7'b000_1110;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // What the currently scanned digit is doing in this cycle.
   typedef enum logic [1:0] {
      MODE_DEAD  = 2'd0,   // anti-ghosting gap at the start of a slot
      MODE_DARK  = 2'd1,   // digit blanked (explicit or leading zero)
      MODE_PWM_O = 2'd2,   // active window, PWM off phase
      MODE_LIT   = 2'd3    // active window, anode driven
   } scan_mode_e;

   // Clock cycles spent on one digit: one frame split evenly over the digits.
   function automatic int unsigned calc_slot_cycles(input int unsigned clk_hz,
                                                    input int unsigned refresh_ms,
                                                    input int unsigned num_digits);
      return (clk_hz / 1000) * refresh_ms / num_digits;
   endfunction

endpackage

// File: rtl/seg7_scan_ctrl_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
//   Combinational hex-digit to 7-segment decoder (active-low outputs).
//   Ports:
//     i_code  in   4  digit code 0-F
//     o_seg   out  7  {CG,CF,CE,CD,CC,CB,CA}, 0 = segment lit
// ---------------------------------------------------------------------------
module seg7_decode
   import seg7_scan_ctrl_pkg::*;
(
   input  logic [3:0] i_code,
   output logic [6:0] o_seg
);

   always_comb begin
      // NOTE: default assigned first so every path drives o_seg and no latch is inferred.
      o_seg = SEG_OFF;
      case (i_code)
         4'h0: o_seg = SEG_0;
         4'h1: o_seg = SEG_1;
         4'h2: o_seg = SEG_2;
         4'h3: o_seg = SEG_3;
         4'h4: o_seg = SEG_4;
         4'h5: o_seg = SEG_5;
         4'h6: o_seg = SEG_6;
         4'h7: o_seg = SEG_7;
         4'h8: o_seg = SEG_8;
         4'h9: o_seg = SEG_9;
         4'hA: o_seg = SEG_A;
         4'hB: o_seg = SEG_B;
         4'hC: o_seg = SEG_C;
         4'hD: o_seg = SEG_D;
         4'hE: o_seg = SEG_E;
         4'hF: o_seg = SEG_F;
         default: o_seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexed common-anode 7-segment controller. Scans the digits from
//   the leftmost (NUM_DIGITS-1) down to 0, gives each digit a slot that begins
//   with an all-off dead time, PWM-dims the remaining window, blanks digits on
//   request or as leading zeros, and swaps in newly loaded content only at a
//   frame boundary so a frame never shows a mix of old and new digits.
//   Ports:
//     clk          in   1             system clock
//     rst          in   1             synchronous active-high reset
//     digits_in    in   4*NUM_DIGITS  digit i code at [4i+3:4i], digit 0 rightmost
//     dp_in        in   NUM_DIGITS    1 = decimal point lit on digit i
//     blank_in     in   NUM_DIGITS    1 = digit i forced dark
//     lz_blank     in   1             1 = suppress leading zeros
//     brightness   in   BRIGHT_W      0 = dark, all-ones = whole window lit
//     load         in   1             capture digits_in/dp_in/blank_in
//     an           out  NUM_DIGITS    anodes, active low
//     seg          out  7             segments {CG..CA}, active low
//     dp           out  1             decimal point, active low
//     frame_start  out  1             pulse on the first cycle of each frame
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
   import seg7_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int CLK_HZ      = 100_000_000,
   parameter int REFRESH_MS  = 16,
   parameter int DEAD_CYCLES = 1000,
   parameter int BRIGHT_W    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_blank,
   input  logic [BRIGHT_W-1:0]     brightness,
   input  logic                    load,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_start
);

   localparam int SLOT_CYCLES = int'(calc_slot_cycles(CLK_HZ, REFRESH_MS, NUM_DIGITS));
   localparam int CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int IDX_W       = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEAD_END  = CNT_W'(DEAD_CYCLES);
   localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(NUM_DIGITS - 1);

   // Scan state
   logic [CNT_W-1:0]        r_slot_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic [BRIGHT_W-1:0]     r_pwm_cnt;

   // Double buffer: pending collects loads, active is what the scan shows
   logic [4*NUM_DIGITS-1:0] r_pend_digits;
   logic [NUM_DIGITS-1:0]   r_pend_dp;
   logic [NUM_DIGITS-1:0]   r_pend_blank;
   logic                    r_pend_flag;
   logic [4*NUM_DIGITS-1:0] r_act_digits;
   logic [NUM_DIGITS-1:0]   r_act_dp;
   logic [NUM_DIGITS-1:0]   r_act_blank;

   // Registered pin drivers
   logic [NUM_DIGITS-1:0]   r_an;
   logic [6:0]              r_seg;
   logic                    r_dp;
   logic                    r_frame_start;

   logic                    w_slot_last;
   logic                    w_frame_wrap;
   logic [CNT_W-1:0]        w_slot_next;
   logic [3:0]              w_code;
   logic [6:0]              w_seg_dec;
   logic [NUM_DIGITS-1:0]   w_lz_mask;
   logic                    w_zero_run;
   logic                    w_dark;
   logic                    w_pwm_on;
   scan_mode_e              w_mode;

   assign w_slot_last  = (r_slot_cnt == SLOT_LAST);
   assign w_slot_next  = w_slot_last ? '0 : r_slot_cnt + 1'b1;
   // Last cycle of the rightmost digit: the next cycle starts a new frame.
   assign w_frame_wrap = w_slot_last && (r_idx == '0);

   // ------------------------------------------------------------------
   // Slot counter, scan index, PWM counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot_cnt <= '0;
         r_idx      <= IDX_FIRST;
         r_pwm_cnt  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
         r_slot_cnt <= w_slot_next;
         // Restart PWM exactly when the active window opens so every slot
         // gets the same lit pattern regardless of window length.
         r_pwm_cnt  <= (w_slot_next == DEAD_END) ? '0 : r_pwm_cnt + 1'b1;
         if (w_slot_last) begin
            r_idx <= (r_idx == '0) ? IDX_FIRST : r_idx - 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Pending/active buffers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the display buffers are ordinary flops, so they are reset; blank=all-ones keeps the display dark until the first load.
         r_pend_digits <= '0;
         r_pend_dp     <= '0;
         r_pend_blank  <= '1;
         r_pend_flag   <= 1'b0;
         r_act_digits  <= '0;
         r_act_dp      <= '0;
         r_act_blank   <= '1;
      end else if (w_frame_wrap) begin
         // A load landing on the wrap cycle bypasses pending so it is not
         // delayed by a whole frame.
         if (load) begin
            r_act_digits <= digits_in;
            r_act_dp     <= dp_in;
            r_act_blank  <= blank_in;
         end else if (r_pend_flag) begin
            r_act_digits <= r_pend_digits;
            r_act_dp     <= r_pend_dp;
            r_act_blank  <= r_pend_blank;
         end
         r_pend_flag <= 1'b0;
      end else if (load) begin
         r_pend_digits <= digits_in;
         r_pend_dp     <= dp_in;
         r_pend_blank  <= blank_in;
         r_pend_flag   <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Leading-zero mask: bit i set when digits N-1..i are all zero.
   // Digit 0 is never suppressed so a zero value still shows "0".
   // ------------------------------------------------------------------
   always_comb begin
      w_lz_mask  = '0;
      w_zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         w_zero_run   = w_zero_run && (r_act_digits[4*i +: 4] == 4'h0);
         w_lz_mask[i] = w_zero_run;
      end
   end

   assign w_code   = r_act_digits[{r_idx, 2'b00} +: 4];
   assign w_dark   = r_act_blank[r_idx] | (lz_blank & w_lz_mask[r_idx]);
   assign w_pwm_on = (&brightness) || (r_pwm_cnt < brightness);

   seg7_decode u_decode (
      .i_code (w_code),
      .o_seg  (w_seg_dec)
   );

   always_comb begin
      w_mode = MODE_DEAD;
      if (r_slot_cnt < DEAD_END) begin
         w_mode = MODE_DEAD;
      end else if (w_dark) begin
         w_mode = MODE_DARK;
      end else if (w_pwm_on) begin
         w_mode = MODE_LIT;
      end else begin
         w_mode = MODE_PWM_O;
      end
   end

   // ------------------------------------------------------------------
   // Output registers: one cycle behind the scan state
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_an          <= '1;
         r_seg         <= SEG_OFF;
         r_dp          <= 1'b1;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= (r_slot_cnt == '0) && (r_idx == IDX_FIRST);
         if (w_mode == MODE_LIT) begin
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg <= w_seg_dec;
            r_dp  <= ~r_act_dp[r_idx];
         end else begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
         end
      end
   end

   assign an          = r_an;
   assign seg         = r_seg;
   assign dp          = r_dp;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//   Self-checking bench for seg7_scan_ctrl at 100-cycle slots (N=4, 10 dead).
//   A cycle-indexed reference model (slot/index derived from the cycle count
//   by division) predicts every output; a table of display scenarios is
//   checked by counting lit cycles per digit over a full frame; hand-written
//   sequences cover mid-frame loads, boundary loads and mid-slot reset.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

   localparam int N          = 4;
   localparam int CLK_HZ     = 100_000;
   localparam int REFRESH_MS = 4;
   localparam int DEAD       = 10;
   localparam int BW         = 4;
   localparam int SLOT       = CLK_HZ / 1000 * REFRESH_MS / N;
   localparam int FRAME      = SLOT * N;

   logic            clk = 1'b0;
   logic            rst;
   logic [4*N-1:0]  digits_in;
   logic [N-1:0]    dp_in;
   logic [N-1:0]    blank_in;
   logic            lz_blank;
   logic [BW-1:0]   brightness;
   logic            load;
   logic [N-1:0]    an;
   logic [6:0]      seg;
   logic            dp;
   logic            frame_start;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .NUM_DIGITS  (N),
      .CLK_HZ      (CLK_HZ),
      .REFRESH_MS  (REFRESH_MS),
      .DEAD_CYCLES (DEAD),
      .BRIGHT_W    (BW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .digits_in   (digits_in),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
      .lz_blank    (lz_blank),
      .brightness  (brightness),
      .load        (load),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_start (frame_start)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Hex digit glyphs, active low {g,f,e,d,c,b,a}
   logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // ------------------------------------------------------------------
   // Reference model: m_j = cycles since reset; slot and digit follow by division.
   // ------------------------------------------------------------------
   int             m_j;
   logic [4*N-1:0] m_act_dig, m_pend_dig;
   logic [N-1:0]   m_act_dp, m_pend_dp, m_act_bl, m_pend_bl;
   bit             m_flag;
   logic [N-1:0]   e_an;
   logic [6:0]     e_seg;
   logic           e_dp, e_fs;
   bit             e_seg_chk;

   function automatic int m_slot();
      return m_j % SLOT;
   endfunction

   function automatic int m_idx();
      return N - 1 - (m_j / SLOT) % N;
   endfunction

   // Predict the outputs of the next cycle from the current cycle's state and inputs.
   task automatic model_edge();
      int slot, idx, w;
      bit lz_dark, dark, lit;
      if (rst) begin
         m_j = 0;
         m_act_dig = '0; m_act_dp = '0; m_act_bl = '1;
         m_pend_dig = '0; m_pend_dp = '0; m_pend_bl = '1;
         m_flag = 1'b0;
         e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0; e_seg_chk = 1'b1;
      end else begin
         slot = m_slot();
         idx  = m_idx();
         lz_dark = 1'b0;
         if (lz_blank && idx != 0) begin
            lz_dark = 1'b1;
            for (int i = N - 1; i >= idx; i--)
               if (m_act_dig[4*i +: 4] != 4'h0) lz_dark = 1'b0;
         end
         dark = m_act_bl[idx] || lz_dark;
         w    = slot - DEAD;
         lit  = (slot >= DEAD) && !dark &&
                ((int'(brightness) == (1 << BW) - 1) || ((w % (1 << BW)) < int'(brightness)));
         e_an = '1;
         if (lit) e_an[idx] = 1'b0;
         e_seg     = seg_ref[m_act_dig[4*idx +: 4]];
         e_dp      = ~m_act_dp[idx];
         e_seg_chk = lit;
         e_fs      = (slot == 0) && (idx == N - 1);
         if (slot == SLOT - 1 && idx == 0) begin
            if (load) begin
               m_act_dig = digits_in; m_act_dp = dp_in; m_act_bl = blank_in;
            end else if (m_flag) begin
               m_act_dig = m_pend_dig; m_act_dp = m_pend_dp; m_act_bl = m_pend_bl;
            end
            m_flag = 1'b0;
         end else if (load) begin
            m_pend_dig = digits_in; m_pend_dp = dp_in; m_pend_bl = blank_in;
            m_flag = 1'b1;
         end
         m_j++;
      end
   endtask

   // Per-frame lit statistics for the table phase
   bit         cnt_en = 1'b0;
   int         lit_cnt [N];
   logic [6:0] seen_seg [N];
   logic       seen_dp [N];

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check($sformatf("an@%0d", m_j), an, e_an);
      check($sformatf("frame_start@%0d", m_j), frame_start, e_fs);
      if (e_seg_chk) begin
         check($sformatf("seg@%0d", m_j), seg, e_seg);
         check($sformatf("dp@%0d", m_j), dp, e_dp);
      end
      if (cnt_en) begin
         for (int i = 0; i < N; i++) begin
            if (an[i] === 1'b0) begin
               lit_cnt[i]++;
               seen_seg[i] = seg;
               seen_dp[i]  = dp;
            end
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int c = 0; c < n; c++) tick();
   endtask

   // Advance to the next cycle showing frame_start (at least one tick).
   task automatic run_until_fs(input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (frame_start !== 1'b1 && n < 2 * FRAME);
      check({tag, "_fs_seen"}, frame_start, 1'b1);
   endtask

   typedef struct packed {
      logic [15:0]     digits;
      logic [3:0]      dpv;
      logic [3:0]      blank;
      logic            lz;
      logic [3:0]      bright;
      logic [3:0][7:0] lit;   // lit cycles per slot, digit i at [i]
      logic [3:0][6:0] segs;  // glyph expected while lit
      logic [3:0]      dps;   // dp pin expected while lit
   } vec_t;

   vec_t tv [8];
   int   cnt;

   initial begin
      tv[0] = '{16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, {8'd90, 8'd90, 8'd90, 8'd90},
                {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
      tv[1] = '{16'h5678, 4'h0, 4'h0, 1'b0, 4'hF, {8'd90, 8'd90, 8'd90, 8'd90},
                {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF};
      tv[2] = '{16'h0050, 4'h0, 4'h0, 1'b1, 4'hF, {8'd0, 8'd0, 8'd90, 8'd90},
                {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};
      tv[3] = '{16'h0000, 4'h0, 4'h0, 1'b1, 4'hF, {8'd0, 8'd0, 8'd0, 8'd90},
                {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
      tv[4] = '{16'h9ABC, 4'h0, 4'h0, 1'b0, 4'h4, {8'd24, 8'd24, 8'd24, 8'd24},
                {7'h10, 7'h08, 7'h03, 7'h46}, 4'hF};
      tv[5] = '{16'hDEF0, 4'h0, 4'h0, 1'b0, 4'h0, {8'd0, 8'd0, 8'd0, 8'd0},
                {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF};
      tv[6] = '{16'h0123, 4'b0101, 4'b0100, 1'b0, 4'hF, {8'd90, 8'd0, 8'd90, 8'd90},
                {7'h40, 7'h7F, 7'h24, 7'h30}, 4'b1110};
      tv[7] = '{16'h0808, 4'h0, 4'h0, 1'b1, 4'hC, {8'd0, 8'd70, 8'd70, 8'd70},
                {7'h7F, 7'h00, 7'h40, 7'h00}, 4'hF};

      // ---------------- reset ----------------
      rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; blank_in = '0;
      lz_blank = 1'b0; brightness = 4'hF;
      ticks(3);
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_dp", dp, 1'b1);
      check("rst_fs", frame_start, 1'b0);
      rst = 1'b0;

      // ---------------- table-driven frames ----------------
      for (int t = 0; t < 8; t++) begin
         digits_in = tv[t].digits; dp_in = tv[t].dpv; blank_in = tv[t].blank;
         lz_blank = tv[t].lz; brightness = tv[t].bright;
         load = 1'b1;
         tick();
         load = 1'b0;
         // Unloaded input changes must not reach the display.
         digits_in = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'($urandom);
         run_until_fs($sformatf("tbl%0d", t));
         for (int i = 0; i < N; i++) begin
            lit_cnt[i] = 0; seen_seg[i] = 7'h7F; seen_dp[i] = 1'b1;
         end
         cnt_en = 1'b1;
         ticks(FRAME);
         cnt_en = 1'b0;
         for (int i = 0; i < N; i++) begin
            check($sformatf("tbl%0d_lit_d%0d", t, i), lit_cnt[i], tv[t].lit[i]);
            if (tv[t].lit[i] != 8'd0) begin
               check($sformatf("tbl%0d_seg_d%0d", t, i), seen_seg[i], tv[t].segs[i]);
               check($sformatf("tbl%0d_dp_d%0d", t, i), seen_dp[i], tv[t].dps[i]);
            end
         end
      end

      // ---------------- load mid-frame: current frame keeps old content ----------------
      lz_blank = 1'b0; brightness = 4'hF; dp_in = '0; blank_in = '0;
      digits_in = 16'h1234; load = 1'b1; tick(); load = 1'b0;
      run_until_fs("mid_a");
      ticks(SLOT + 50);                       // inside digit 2's slot
      digits_in = 16'h5678; load = 1'b1; tick(); load = 1'b0;
      ticks(99);                              // middle of digit 1's slot
      check("mid_old_an", an, 4'b1101);
      check("mid_old_seg", seg, 7'h30);
      run_until_fs("mid_b");
      ticks(DEAD + 5);
      check("mid_new_an", an, 4'b0111);
      check("mid_new_seg", seg, 7'h12);

      // ---------------- load exactly on the frame wrap cycle ----------------
      cnt = 0;
      while (!(m_slot() == SLOT - 1 && m_idx() == 0) && cnt < 2 * FRAME) begin
         tick();
         cnt++;
      end
      check("bnd_found", (m_slot() == SLOT - 1 && m_idx() == 0), 1'b1);
      digits_in = 16'h9876; load = 1'b1; tick(); load = 1'b0;
      digits_in = 16'h1111;
      run_until_fs("bnd");
      ticks(DEAD + 5);
      check("bnd_an", an, 4'b0111);
      check("bnd_seg", seg, 7'h10);

      // ---------------- reset in the middle of a lit slot ----------------
      cnt = 0;
      while (an === 4'hF && cnt < 2 * SLOT) begin
         tick();
         cnt++;
      end
      ticks(7);
      rst = 1'b1; tick();
      check("mrst_an", an, 4'hF);
      check("mrst_seg", seg, 7'h7F);
      check("mrst_dp", dp, 1'b1);
      rst = 1'b0; tick();
      check("mrst_fs", frame_start, 1'b1);
      cnt = 0;
      for (int c = 0; c < 2 * FRAME; c++) begin
         tick();
         if (an !== 4'hF) cnt++;
      end
      check("mrst_dark_cycles", cnt, 0);
      digits_in = 16'h4321; load = 1'b1; tick(); load = 1'b0;
      run_until_fs("mrst");
      ticks(DEAD + 1);
      check("mrst_first_an", an, 4'b0111);
      check("mrst_first_seg", seg, 7'h19);

      // ---------------- randomized traffic against the model ----------------
      for (int r = 0; r < 24; r++) begin
         logic [15:0] d;
         int          n;
         d = 16'($urandom);
         case ($urandom_range(0, 3))
            0: d = d & 16'h00FF;
            1: d = d & 16'h000F;
            default: ;
         endcase
         digits_in  = d;
         dp_in      = 4'($urandom);
         blank_in   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         lz_blank   = 1'($urandom);
         brightness = 4'($urandom);
         load = 1'b1;
         tick();
         if ($urandom_range(0, 2) == 0) begin
            digits_in = 16'($urandom);
            tick();
         end
         load = 1'b0;
         digits_in = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'($urandom);
         n = $urandom_range(40, 700);
         for (int c = 0; c < n; c++) begin
            if ($urandom_range(0, 199) == 0) brightness = 4'($urandom);
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
